// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the parametrised register file.
// Optional write-first forwarding is enabled with the REGFILE_BYPASS_EN macro.
package regfile_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefAddrW = 4;
  localparam int unsigned DefHiIdx = 12;
  localparam int unsigned DefLoIdx = 13;
  localparam int unsigned DefSrIdx = 9;
  localparam int unsigned DefBaIdx = 10;

  // Registers the writeback port may not touch: the zero register and the shadow targets.
  function automatic logic is_protected(input int unsigned addr,
                                        input int unsigned hiIdx = DefHiIdx,
                                        input int unsigned loIdx = DefLoIdx,
                                        input int unsigned srIdx = DefSrIdx);
    return (addr == 0) || (addr == hiIdx) || (addr == loIdx) || (addr == srIdx);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits (set at issue, cleared at writeback) and the decode hazard.
// Forwarded sources (REGFILE_BYPASS_EN builds) are masked out of the hazard by the top.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk,
  input  logic              rest_n,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic              fwd1,
  input  logic              fwd2,
  output logic              hazard
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [Depth-1:0] busyQ, busyD;

  // Clear first so a same-cycle issue to the same destination wins.
  always_comb begin
    busyD = busyQ;
    if (wr_en) busyD[wr_addr] = 1'b0;
    if (busy_set && (busy_addr != '0)) busyD[busy_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) busyQ <= '0;
    else         busyQ <= busyD;
  end

  assign hazard = rd_en & ((busyQ[rd_addr1] & ~fwd1) | (busyQ[rd_addr2] & ~fwd2));

endmodule

// File: rtl/param_regfile.sv
// Parametrised register file: two registered read ports, one writeback port, HI/LO/SR
// shadow loads and a busy scoreboard. Define REGFILE_BYPASS_EN for write-first forwarding.
module param_regfile
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned HI_IDX = DefHiIdx,
  parameter int unsigned LO_IDX = DefLoIdx,
  parameter int unsigned SR_IDX = DefSrIdx,
  parameter int unsigned BA_IDX = DefBaIdx
) (
  input  logic              clk,
  input  logic              rest_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              spec_we,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  input  logic [DATA_W-1:0] sr_in,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_addr,
  output logic              hazard,
  output logic              sr_flag,
  output logic [DATA_W-1:0] ba
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] HiAddr = ADDR_W'(HI_IDX);
  localparam logic [ADDR_W-1:0] LoAddr = ADDR_W'(LO_IDX);
  localparam logic [ADDR_W-1:0] SrAddr = ADDR_W'(SR_IDX);
  localparam logic [ADDR_W-1:0] BaAddr = ADDR_W'(BA_IDX);

  logic [DATA_W-1:0] regQ [Depth];
  logic              wrOk;
  logic              fwd1, fwd2;
  logic [DATA_W-1:0] rdNext1, rdNext2;

  assign wrOk = wr_en & ~is_protected(32'(wr_addr), HI_IDX, LO_IDX, SR_IDX);

`ifdef REGFILE_BYPASS_EN
  // Write-first: a source written on this edge sees the incoming value.
  function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] addr);
    if (spec_we && (addr == HiAddr)) return hi_in;
    if (spec_we && (addr == LoAddr)) return lo_in;
    if (spec_we && (addr == SrAddr)) return sr_in;
    if (wrOk && (addr == wr_addr))   return wr_data;
    return regQ[addr];
  endfunction

  assign fwd1 = wrOk & (wr_addr == rd_addr1);
  assign fwd2 = wrOk & (wr_addr == rd_addr2);
`else
  function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] addr);
    return regQ[addr];
  endfunction

  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  always_comb begin
    rdNext1 = readPort(rd_addr1);
    rdNext2 = readPort(rd_addr2);
  end

  regfile_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rest_n   (rest_n),
    .busy_set (busy_set),
    .busy_addr(busy_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rd_en    (rd_en),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .fwd1     (fwd1),
    .fwd2     (fwd2),
    .hazard   (hazard)
  );

  // Register 0 is never written (protected), so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      for (int i = 0; i < Depth; i++) regQ[i] <= '0;
      rd_data1 <= '0;
      rd_data2 <= '0;
      sr_flag  <= 1'b0;
      ba       <= '0;
    end else begin
      if (wrOk) regQ[wr_addr] <= wr_data;
      if (spec_we) begin
        regQ[HiAddr] <= hi_in;
        regQ[LoAddr] <= lo_in;
        regQ[SrAddr] <= sr_in;
      end
      if (rd_en && !hazard) begin
        rd_data1 <= rdNext1;
        rd_data2 <= rdNext2;
      end
      sr_flag <= regQ[SrAddr][DATA_W-1];
      ba      <= regQ[BaAddr];
    end
  end

endmodule

// File: tb/tb_param_regfile.sv
// Scoreboard bench for param_regfile: default 16x16 instance against a reference model,
// plus a 32-bit x 32-entry instance with directed checks.
module tb_param_regfile;

`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rest_n;
  logic        rd_en, wr_en, spec_we, busy_set;
  logic [3:0]  rd_addr1, rd_addr2, wr_addr, busy_addr;
  logic [15:0] wr_data, hi_in, lo_in, sr_in;
  logic [15:0] rd_data1, rd_data2, ba;
  logic        hazard, sr_flag;

  logic        wRdEn, wWrEn;
  logic [4:0]  wRdAddr1, wWrAddr;
  logic [31:0] wWrData, wRdData1, wRdData2, wBa;
  logic        wHazard, wSrFlag;

  always #5 clk = ~clk;

  param_regfile u_dut (
    .clk      (clk),
    .rest_n   (rest_n),
    .rd_en    (rd_en),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .spec_we  (spec_we),
    .hi_in    (hi_in),
    .lo_in    (lo_in),
    .sr_in    (sr_in),
    .busy_set (busy_set),
    .busy_addr(busy_addr),
    .hazard   (hazard),
    .sr_flag  (sr_flag),
    .ba       (ba)
  );

  param_regfile #(
    .DATA_W(32),
    .ADDR_W(5)
  ) u_dut32 (
    .clk      (clk),
    .rest_n   (rest_n),
    .rd_en    (wRdEn),
    .rd_addr1 (wRdAddr1),
    .rd_addr2 (5'd0),
    .rd_data1 (wRdData1),
    .rd_data2 (wRdData2),
    .wr_en    (wWrEn),
    .wr_addr  (wWrAddr),
    .wr_data  (wWrData),
    .spec_we  (1'b0),
    .hi_in    (32'd0),
    .lo_in    (32'd0),
    .sr_in    (32'd0),
    .busy_set (1'b0),
    .busy_addr(5'd0),
    .hazard   (wHazard),
    .sr_flag  (wSrFlag),
    .ba       (wBa)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] mdl[16];
  bit          mBusy[16];
  logic [15:0] mRd1, mRd2;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    expQ.push_back(e);
  endtask

  task automatic popCheck(input logic [31:0] obs);
    exp_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL queue: got empty want entry");
    end else begin
      e = expQ.pop_front();
      checkVal(e.tag, obs, e.exp);
    end
  endtask

  function automatic bit prot(input logic [3:0] a);
    return (a == 4'd0) || (a == 4'd9) || (a == 4'd12) || (a == 4'd13);
  endfunction

  function automatic logic [15:0] mRead(input logic [3:0] a);
    if (Bypass) begin
      if (spec_we && a == 4'd9)  return sr_in;
      if (spec_we && a == 4'd12) return hi_in;
      if (spec_we && a == 4'd13) return lo_in;
      if (wr_en && a == wr_addr && !prot(a)) return wr_data;
    end
    return mdl[a];
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin
      mdl[i]   = '0;
      mBusy[i] = 1'b0;
    end
    mRd1 = '0;
    mRd2 = '0;
    expQ.delete();
  endtask

  task automatic idle();
    rd_en = 0; wr_en = 0; spec_we = 0; busy_set = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock of the default instance: check hazard, queue expected outputs, advance model.
  task automatic step();
    bit e1, e2, hz;
    #1;
    e1 = Bypass && wr_en && (wr_addr == rd_addr1) && !prot(wr_addr);
    e2 = Bypass && wr_en && (wr_addr == rd_addr2) && !prot(wr_addr);
    hz = rd_en && ((mBusy[rd_addr1] && !e1) || (mBusy[rd_addr2] && !e2));
    checkVal("hazard", 32'(hazard), 32'(hz));
    if (rd_en && !hz) begin
      mRd1 = mRead(rd_addr1);
      mRd2 = mRead(rd_addr2);
    end
    pushExp("rd_data1", 32'(mRd1));
    pushExp("rd_data2", 32'(mRd2));
    pushExp("ba", 32'(mdl[10]));
    pushExp("sr_flag", 32'(mdl[9][15]));
    if (wr_en && !prot(wr_addr)) mdl[wr_addr] = wr_data;
    if (spec_we) begin
      mdl[12] = hi_in;
      mdl[13] = lo_in;
      mdl[9]  = sr_in;
    end
    if (wr_en) mBusy[wr_addr] = 1'b0;
    if (busy_set && busy_addr != 4'd0) mBusy[busy_addr] = 1'b1;
    tick();
    popCheck(32'(rd_data1));
    popCheck(32'(rd_data2));
    popCheck(32'(ba));
    popCheck(32'(sr_flag));
  endtask

  task automatic write(input logic [3:0] a, input logic [15:0] d);
    idle();
    wr_en = 1; wr_addr = a; wr_data = d;
    step();
  endtask

  task automatic read(input logic [3:0] a1, input logic [3:0] a2);
    idle();
    rd_en = 1; rd_addr1 = a1; rd_addr2 = a2;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] old7;
    rest_n = 0;
    idle();
    rd_addr1 = 0; rd_addr2 = 0; wr_addr = 0; busy_addr = 0;
    wr_data = 0; hi_in = 0; lo_in = 0; sr_in = 0;
    wRdEn = 0; wWrEn = 0; wRdAddr1 = 0; wWrAddr = 0; wWrData = 0;
    modelReset();
    #3;
    checkVal("rst_rd1", 32'(rd_data1), 0);
    checkVal("rst_rd2", 32'(rd_data2), 0);
    checkVal("rst_ba", 32'(ba), 0);
    checkVal("rst_sr", 32'(sr_flag), 0);
    checkVal("rst_hazard", 32'(hazard), 0);
    @(negedge clk);
    rest_n = 1;
    tick();

    // Write then read, and ignored writes to protected registers.
    write(4'd3, 16'hBEEF);
    read(4'd3, 4'd0);
    checkVal("wr_rd3", 32'(rd_data1), 32'h0000_BEEF);
    write(4'd0, 16'h1111);
    write(4'd12, 16'h2222);
    write(4'd9, 16'h3333);
    read(4'd0, 4'd12);
    checkVal("wr0_ignored", 32'(rd_data1), 0);
    checkVal("wrhi_ignored", 32'(rd_data2), 0);
    read(4'd9, 4'd3);
    checkVal("wrsr_ignored", 32'(rd_data1), 0);

    // Shadow load.
    idle();
    spec_we = 1; sr_in = 16'h8001; hi_in = 16'h1234; lo_in = 16'h0F0F;
    step();
    read(4'd9, 4'd12);
    checkVal("shadow_sr", 32'(rd_data1), 32'h8001);
    checkVal("shadow_hi", 32'(rd_data2), 32'h1234);
    checkVal("sr_flag", 32'(sr_flag), 1);

    // Scoreboard.
    idle();
    busy_set = 1; busy_addr = 4'd5;
    step();
    idle();
    rd_en = 1; rd_addr1 = 4'd3; rd_addr2 = 4'd5;
    #1;
    checkVal("busy_hazard", 32'(hazard), 1);
    step();
    write(4'd5, 16'h00AA);
    read(4'd3, 4'd5);
    checkVal("busy_clear_rd", 32'(rd_data2), 32'h00AA);
    idle();
    busy_set = 1; busy_addr = 4'd5; wr_en = 1; wr_addr = 4'd5; wr_data = 16'h0055;
    step();
    read(4'd5, 4'd0);
    checkVal("set_wins", 32'(hazard), 1);
    write(4'd5, 16'h0066);
    read(4'd5, 4'd5);

    // Same-cycle write and read.
    old7 = mdl[7];
    idle();
    wr_en = 1; wr_addr = 4'd7; wr_data = 16'h5A5A;
    rd_en = 1; rd_addr1 = 4'd7; rd_addr2 = 4'd3;
    step();
    checkVal("bypass", 32'(rd_data1), Bypass ? 32'h5A5A : 32'(old7));

    // ba tracks register 10 with one edge of lag.
    write(4'd10, 16'hCAFE);
    idle();
    step();
    checkVal("ba_track", 32'(ba), 32'hCAFE);

    // Randomised traffic against the model.
    for (int n = 0; n < 80; n++) begin
      rd_en     = ($urandom_range(0, 1) == 1);
      wr_en     = ($urandom_range(0, 1) == 1);
      spec_we   = ($urandom_range(0, 7) == 0);
      busy_set  = ($urandom_range(0, 3) == 0);
      rd_addr1  = 4'($urandom_range(0, 15));
      rd_addr2  = 4'($urandom_range(0, 15));
      wr_addr   = 4'($urandom_range(0, 15));
      busy_addr = 4'($urandom_range(0, 15));
      wr_data   = 16'($urandom);
      hi_in     = 16'($urandom);
      lo_in     = 16'($urandom);
      sr_in     = 16'($urandom);
      step();
    end

    // Wide instance.
    idle();
    wWrEn = 1; wWrAddr = 5'd31; wWrData = 32'hDEADBEEF;
    tick();
    wWrEn = 0; wRdEn = 1; wRdAddr1 = 5'd31;
    pushExp("w_rd31", 32'hDEADBEEF);
    tick();
    popCheck(wRdData1);
    wRdEn = 0; wWrEn = 1; wWrAddr = 5'd10; wWrData = 32'h1234_5678;
    tick();
    wWrEn = 0;
    pushExp("w_ba", 32'h1234_5678);
    tick();
    popCheck(wBa);

    // Mid-cycle reset with a busy register pending.
    idle();
    busy_set = 1; busy_addr = 4'd6;
    step();
    idle();
    rd_en = 1; rd_addr1 = 4'd6; rd_addr2 = 4'd3;
    #2;
    rest_n = 0;
    #1;
    checkVal("mid_rst_rd1", 32'(rd_data1), 0);
    checkVal("mid_rst_rd2", 32'(rd_data2), 0);
    checkVal("mid_rst_ba", 32'(ba), 0);
    checkVal("mid_rst_sr", 32'(sr_flag), 0);
    checkVal("mid_rst_hazard", 32'(hazard), 0);
    checkVal("mid_rst_wba", wBa, 0);
    modelReset();
    @(negedge clk);
    rest_n = 1;
    tick();
    read(4'd6, 4'd3);
    read(4'd3, 4'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
